cpu_clock_controller: RTL and testbench

//   Run-control scheduler for the processor core's divided clock. Generates a one-cycle

---
 rtl/cpu_clock_controller.sv | 138 +++++++++++++
 tb/tb_cpu_clock_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_controller.sv
// Run-control scheduler for the core's divided clock: issues one-cycle cpu_ce pulses
// every 2^div_q input clocks, with RUN / HALT / single-STEP and breakpoint halting.
module cpu_clock_controller #(
    parameter int MAX_DIV_SEL = 15,
    parameter int CE_CNT_W    = 32,
    parameter bit RESET_RUN   = 1'b0
) (
    input  logic                in_clk,
    input  logic                rst,
    input  logic [3:0]          div_sel,
    input  logic                run_req,
    input  logic                halt_req,
    input  logic                step_req,
    input  logic                bp_hit,
    input  logic                cnt_clr,
    output logic                cpu_ce,
    output logic [1:0]          state,
    output logic                halted_by_bp,
    output logic [CE_CNT_W-1:0] ce_count
);

    localparam int CNT_W = (MAX_DIV_SEL > 0) ? MAX_DIV_SEL : 1;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } run_state_t;

    run_state_t          state_q, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [3:0]          div_q, div_q_n;
    logic                ce_q, ce_n;
    logic                hbp_q, hbp_n;
    logic                bp_skip, bp_skip_n;
    logic                step_prev;
    logic [CE_CNT_W-1:0] count_q, count_n;

    logic [3:0]          div_clamped;
    logic [CNT_W-1:0]    cnt_last;
    logic                at_last;
    logic                step_rise;
    logic                pulse;

    // Compare in 32 bits so the clamp stays well-formed even when MAX_DIV_SEL is 15.
    assign div_clamped = (32'(div_sel) > 32'(MAX_DIV_SEL)) ? 4'(MAX_DIV_SEL) : div_sel;
    assign cnt_last    = CNT_W'((32'd1 << div_q) - 32'd1);
    assign at_last     = (cnt == cnt_last);
    assign step_rise   = step_req & ~step_prev;

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt;
        div_q_n   = div_q;
        hbp_n     = hbp_q;
        bp_skip_n = bp_skip;
        pulse     = 1'b0;

        case (state_q)
            ST_HALT: begin
                // Leaving a breakpoint halt arms bp_skip so the resumed core can step past it.
                if (!halt_req && (run_req || step_rise)) begin
                    state_n   = run_req ? ST_RUN : ST_STEP;
                    cnt_n     = '0;
                    div_q_n   = div_clamped;
                    bp_skip_n = hbp_q;
                    hbp_n     = 1'b0;
                end
            end
            ST_RUN, ST_STEP: begin
                if (halt_req) begin
                    state_n = ST_HALT;
                    cnt_n   = '0;
                    hbp_n   = 1'b0;
                end else if (at_last) begin
                    if (bp_hit && !bp_skip) begin
                        state_n = ST_HALT;
                        cnt_n   = '0;
                        hbp_n   = 1'b1;
                    end else begin
                        pulse     = 1'b1;
                        cnt_n     = '0;
                        bp_skip_n = 1'b0;
                        if (state_q == ST_STEP) begin
                            state_n = ST_HALT;
                        end else begin
                            div_q_n = div_clamped;
                        end
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_HALT;
                cnt_n   = '0;
            end
        endcase

        ce_n = pulse;

        if (cnt_clr) begin
            count_n = pulse ? CE_CNT_W'(1) : '0;
        end else if (pulse) begin
            count_n = count_q + 1'b1;
        end else begin
            count_n = count_q;
        end
    end

    always_ff @(posedge in_clk) begin
        if (rst) begin
            state_q   <= RESET_RUN ? ST_RUN : ST_HALT;
            cnt       <= '0;
            div_q     <= '0;
            ce_q      <= 1'b0;
            hbp_q     <= 1'b0;
            bp_skip   <= 1'b0;
            step_prev <= 1'b1;
            count_q   <= '0;
        end else begin
            state_q   <= state_n;
            cnt       <= cnt_n;
            div_q     <= div_q_n;
            ce_q      <= ce_n;
            hbp_q     <= hbp_n;
            bp_skip   <= bp_skip_n;
            step_prev <= step_req;
            count_q   <= count_n;
        end
    end

    assign cpu_ce       = ce_q;
    assign state        = state_q;
    assign halted_by_bp = hbp_q;
    assign ce_count     = count_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Self-checking bench for cpu_clock_controller: a table of per-cycle vectors fed through
// an expected-value queue, plus a hand-written long-period sequence.
module tb_cpu_clock_controller;

    localparam int CW = 8;

    logic          in_clk;
    logic          rst;
    logic [3:0]    div_sel;
    logic          run_req;
    logic          halt_req;
    logic          step_req;
    logic          bp_hit;
    logic          cnt_clr;
    logic          cpu_ce;
    logic [1:0]    state;
    logic          halted_by_bp;
    logic [CW-1:0] ce_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       run;
        logic       halt;
        logic       step;
        logic       bp;
        logic       clr;
        logic [3:0] div;
        logic       ce;
        logic [1:0] st;
        logic       hbp;
        logic [7:0] cnt;
        string      tag;
    } vec_t;

    vec_t vecs[$];
    vec_t expQ[$];
    int   periodQ[$];

    cpu_clock_controller #(
        .MAX_DIV_SEL(15),
        .CE_CNT_W(CW),
        .RESET_RUN(1'b0)
    ) dut (
        .in_clk(in_clk),
        .rst(rst),
        .div_sel(div_sel),
        .run_req(run_req),
        .halt_req(halt_req),
        .step_req(step_req),
        .bp_hit(bp_hit),
        .cnt_clr(cnt_clr),
        .cpu_ce(cpu_ce),
        .state(state),
        .halted_by_bp(halted_by_bp),
        .ce_count(ce_count)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic addVec(input logic r, input logic run, input logic halt, input logic step,
                          input logic bp, input logic clr, input int div, input logic ce,
                          input int st, input logic hbp, input int cnt, input string tag);
        vec_t v;
        v.rst = r; v.run = run; v.halt = halt; v.step = step; v.bp = bp; v.clr = clr;
        v.div = 4'(div); v.ce = ce; v.st = 2'(st); v.hbp = hbp; v.cnt = 8'(cnt); v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        e = expQ.pop_front();
        checks++;
        if (cpu_ce !== e.ce || state !== e.st || halted_by_bp !== e.hbp || ce_count !== e.cnt) begin
            errors++;
            $display("[TB] FAIL %s: got ce=%0b state=%0d hbp=%0b count=%0d, expected ce=%0b state=%0d hbp=%0b count=%0d",
                     e.tag, cpu_ce, state, halted_by_bp, ce_count, e.ce, e.st, e.hbp, e.cnt);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge in_clk);
        rst = v.rst; run_req = v.run; halt_req = v.halt; step_req = v.step;
        bp_hit = v.bp; cnt_clr = v.clr; div_sel = v.div;
        expQ.push_back(v);
        @(posedge in_clk);
        #1;
        checkOutput();
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        int  c;
        int  cycles;
        bit  seen;
        logic p;

        rst = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        bp_hit = 1'b0; cnt_clr = 1'b0; div_sel = 4'd0;

        // P=4 free run: pulses at entry+4, +8, +12.
        addVec(1,0,0,0,0,0,2, 0,0,0,0, "reset");
        addVec(0,1,0,0,0,0,2, 0,1,0,0, "run_entry");
        c = 0;
        for (int i = 1; i <= 12; i++) begin
            p = (i % 4 == 0);
            if (p) c++;
            addVec(0,0,0,0,0,0,2, p,1,0,c, "run_p4");
        end

        // P=1: continuous enable, dropped by halt at once.
        addVec(0,0,1,0,0,0,2, 0,0,0,c, "halt");
        addVec(0,1,0,0,0,0,0, 0,1,0,c, "run_p1_entry");
        for (int i = 1; i <= 10; i++) begin
            c++;
            addVec(0,0,0,0,0,0,0, 1,1,0,c, "run_p1");
        end
        addVec(0,0,1,0,0,0,0, 0,0,0,c, "halt_p1");

        // Held step button gives exactly one pulse at entry+8.
        addVec(0,0,0,1,0,0,3, 0,2,0,c, "step_entry");
        for (int i = 1; i <= 49; i++) begin
            p = (i == 8);
            if (p) c++;
            addVec(0,0,0,1,0,0,3, p, (i < 8) ? 2 : 0, 0, c, "step_held");
        end
        addVec(0,0,0,0,0,0,3, 0,0,0,c, "step_release");

        // Breakpoint halt, then resume past it and halt at the following boundary.
        addVec(0,1,0,0,0,0,2, 0,1,0,c, "bp_run_entry");
        for (int i = 1; i <= 3; i++) addVec(0,0,0,0,0,0,2, 0,1,0,c, "bp_run");
        addVec(0,0,0,0,1,0,2, 0,0,1,c, "bp_halt");
        addVec(0,1,0,0,1,0,2, 0,1,0,c, "bp_resume");
        for (int i = 1; i <= 8; i++) begin
            p = (i == 4);
            if (p) c++;
            addVec(0,0,0,0,1,0,2, p, (i == 8) ? 0 : 1, (i == 8), c, "bp_skip");
        end

        // halt_req coinciding with the period boundary wins over the pulse.
        addVec(0,1,0,0,0,0,1, 0,1,0,c, "hb_entry");
        addVec(0,0,0,0,0,0,1, 0,1,0,c, "hb_run");
        addVec(0,0,1,0,0,0,1, 0,0,0,c, "halt_at_boundary");

        // div_sel 2->5 mid-period takes effect only after the next pulse.
        addVec(0,1,0,0,0,0,2, 0,1,0,c, "div_entry");
        addVec(0,0,0,0,0,0,2, 0,1,0,c, "div_run");
        for (int i = 2; i <= 36; i++) begin
            p = (i == 4) || (i == 36);
            if (p) c++;
            addVec(0,0,0,0,0,0,5, p,1,0,c, "div_change");
        end
        addVec(0,0,1,0,0,0,5, 0,0,0,c, "div_halt");

        // Counter clear alone, clear with a pulse, then wrap of the 8-bit count.
        addVec(0,0,0,0,0,1,0, 0,0,0,0, "clr_alone");
        addVec(0,1,0,0,0,0,0, 0,1,0,0, "clr_entry");
        addVec(0,0,0,0,0,1,0, 1,1,0,1, "clr_with_pulse");
        c = 1;
        for (int i = 1; i <= 255; i++) begin
            c = (c + 1) % 256;
            addVec(0,0,0,0,0,0,0, 1,1,0,c, "wrap");
        end
        addVec(0,0,1,0,0,0,0, 0,0,0,0, "wrap_halt");

        // STEP aborted by halt, then reset in the middle of a step.
        addVec(0,0,0,1,0,0,2, 0,2,0,0, "step2_entry");
        addVec(0,0,0,0,0,0,2, 0,2,0,0, "step2_run");
        addVec(0,0,1,0,0,0,2, 0,0,0,0, "step_halt_abort");
        addVec(0,1,0,0,0,0,0, 0,1,0,0, "one_entry");
        addVec(0,0,1,0,0,0,0, 0,0,0,0, "halt_beats_pulse");
        addVec(0,1,0,0,0,0,0, 0,1,0,0, "one_entry2");
        addVec(0,0,0,0,0,0,0, 1,1,0,1, "one_pulse");
        addVec(0,0,1,0,0,0,0, 0,0,0,1, "one_halt");
        addVec(0,0,0,1,0,0,3, 0,2,0,1, "step3_entry");
        addVec(0,0,0,1,0,0,3, 0,2,0,1, "step3_run");
        addVec(0,0,0,1,0,0,3, 0,2,0,1, "step3_run");
        addVec(1,0,0,1,0,0,3, 0,0,0,0, "rst_in_step");
        addVec(0,0,0,1,0,0,3, 0,0,0,0, "held_step_after_rst");
        addVec(0,0,0,0,0,0,3, 0,0,0,0, "step_low");
        addVec(0,0,0,1,0,0,3, 0,2,0,0, "step_after_release");
        addVec(1,0,0,0,0,0,3, 0,0,0,0, "final_reset");

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Largest divider: first pulse exactly 32768 edges after entry.
        @(negedge in_clk);
        rst = 1'b0; run_req = 1'b1; div_sel = 4'd15;
        periodQ.push_back(32768);
        @(posedge in_clk);
        #1;
        checkValue("p32768_entry_state", int'(state), 1);
        @(negedge in_clk);
        run_req = 1'b0;
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < 40000) begin
            @(posedge in_clk);
            #1;
            cycles++;
            if (cpu_ce) seen = 1'b1;
        end
        if (!seen) $display("[TB] FAIL p32768_timeout: no pulse within %0d cycles, expected one at 32768", cycles);
        checkValue("p32768_period", seen ? cycles : -1, periodQ.pop_front());
        checkValue("p32768_count", int'(ce_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
